lsu_mshr_resp_arb: RTL

LSU_MSHR_RESP_ARB -- requirements
Module: lsu_mshr_resp_arb

---
 rtl/lsu_mshr_resp_arb.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/lsu_mshr_resp_arb.sv
// lsu_mshr_resp_arb
// Merges the dcache (dc) and shared-memory (sh) response streams into the
// single MSHR response port. Each source has a one-entry holding buffer, so
// the input-to-output latency is one cycle. A source can refill in the same
// cycle its buffer drains. A grant that meets backpressure is locked, which
// keeps the presented beat stable until it is taken.
//
// Optional feature macro: LSU_MSHR_RESP_ARB_RR_EN
//   defined   -> round-robin between dc and sh when both buffers are full
//   undefined -> fixed priority, dc over sh (no pointer register)
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   {dc,sh}_valid_i/_ready_o    per-source input handshake
//   {dc,sh}_instrid_i           MSHR entry id of the response
//   {dc,sh}_data_i              per-thread response data (XLEN*NUM_THREAD)
//   {dc,sh}_activemask_i        per-thread active mask
//   to_mshr_valid_o/_ready_i    output handshake toward the MSHR
//   to_mshr_instrid_o/_data_o/_activemask_o  payload of the granted buffer
//   to_mshr_src_o               granted source, 0 = dc, 1 = sh
//   busy_o                      high while any holding buffer is full
module lsu_mshr_resp_arb #(
  parameter int LSU_NMSHRENTRY = 8,
  parameter int XLEN           = 32,
  parameter int NUM_THREAD     = 4,
  localparam int IDW = (LSU_NMSHRENTRY > 1) ? $clog2(LSU_NMSHRENTRY) : 1,
  localparam int DW  = XLEN * NUM_THREAD
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dc_valid_i,
  output logic                  dc_ready_o,
  input  logic [IDW-1:0]        dc_instrid_i,
  input  logic [DW-1:0]         dc_data_i,
  input  logic [NUM_THREAD-1:0] dc_activemask_i,
  input  logic                  sh_valid_i,
  output logic                  sh_ready_o,
  input  logic [IDW-1:0]        sh_instrid_i,
  input  logic [DW-1:0]         sh_data_i,
  input  logic [NUM_THREAD-1:0] sh_activemask_i,
  output logic                  to_mshr_valid_o,
  input  logic                  to_mshr_ready_i,
  output logic [IDW-1:0]        to_mshr_instrid_o,
  output logic [DW-1:0]         to_mshr_data_o,
  output logic [NUM_THREAD-1:0] to_mshr_activemask_o,
  output logic                  to_mshr_src_o,
  output logic                  busy_o
);

  logic                  full_dc_q, full_dc_d;
  logic                  full_sh_q, full_sh_d;
  logic                  lock_q, lock_d;
  logic                  lock_src_q, lock_src_d;
  logic [IDW-1:0]        dc_id_q, sh_id_q;
  logic [DW-1:0]         dc_data_q, sh_data_q;
  logic [NUM_THREAD-1:0] dc_mask_q, sh_mask_q;

  logic grant;     // 0 = dc, 1 = sh
  logic hs;
  logic acc_dc, acc_sh;

`ifdef LSU_MSHR_RESP_ARB_RR_EN
  // Value of the pointer is the source favoured on the next contention.
  logic rr_ptr_q, rr_ptr_d;
`endif

  always_comb begin
    if (lock_q) begin
      grant = lock_src_q;
    end else if (full_dc_q && full_sh_q) begin
`ifdef LSU_MSHR_RESP_ARB_RR_EN
      grant = rr_ptr_q;
`else
      grant = 1'b0;
`endif
    end else begin
      grant = !full_dc_q && full_sh_q;
    end
  end

  assign to_mshr_valid_o = full_dc_q || full_sh_q;
  assign hs              = to_mshr_valid_o && to_mshr_ready_i;
  assign busy_o          = full_dc_q || full_sh_q;
  assign to_mshr_src_o   = grant;

  // A full buffer still accepts when it is the one draining this cycle.
  assign dc_ready_o = !full_dc_q || (!grant && to_mshr_ready_i);
  assign sh_ready_o = !full_sh_q || (grant && to_mshr_ready_i);
  assign acc_dc     = dc_valid_i && dc_ready_o;
  assign acc_sh     = sh_valid_i && sh_ready_o;

  assign to_mshr_instrid_o    = grant ? sh_id_q   : dc_id_q;
  assign to_mshr_data_o       = grant ? sh_data_q : dc_data_q;
  assign to_mshr_activemask_o = grant ? sh_mask_q : dc_mask_q;

  always_comb begin
    full_dc_d  = full_dc_q;
    full_sh_d  = full_sh_q;
    lock_d     = lock_q;
    lock_src_d = lock_src_q;
    // Capture wins over drain so a same-cycle refill keeps the buffer full.
    if (acc_dc) full_dc_d = 1'b1;
    else if (hs && !grant) full_dc_d = 1'b0;
    if (acc_sh) full_sh_d = 1'b1;
    else if (hs && grant) full_sh_d = 1'b0;
    if (hs) begin
      lock_d = 1'b0;
    end else if (to_mshr_valid_o) begin
      lock_d     = 1'b1;
      lock_src_d = grant;
    end
  end

`ifdef LSU_MSHR_RESP_ARB_RR_EN
  assign rr_ptr_d = hs ? !grant : rr_ptr_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_dc_q  <= 1'b0;
      full_sh_q  <= 1'b0;
      lock_q     <= 1'b0;
      lock_src_q <= 1'b0;
`ifdef LSU_MSHR_RESP_ARB_RR_EN
      rr_ptr_q   <= 1'b0;
`endif
    end else begin
      full_dc_q  <= full_dc_d;
      full_sh_q  <= full_sh_d;
      lock_q     <= lock_d;
      lock_src_q <= lock_src_d;
`ifdef LSU_MSHR_RESP_ARB_RR_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end

  // Payload registers carry no reset; the full flags qualify them.
  always_ff @(posedge clk) begin
    if (acc_dc) begin
      dc_id_q   <= dc_instrid_i;
      dc_data_q <= dc_data_i;
      dc_mask_q <= dc_activemask_i;
    end
    if (acc_sh) begin
      sh_id_q   <= sh_instrid_i;
      sh_data_q <= sh_data_i;
      sh_mask_q <= sh_activemask_i;
    end
  end

endmodule
